// File: rtl/move_sequencer.sv
// move_sequencer: debounces the four direction buttons, issues one encoded
// move at a time to the combinational collision detector, waits for its
// result to settle and commits the returned position.
// Optional feature macro: MOVE_AUTOREPEAT_EN (auto-repeat while held in HOLD).
module move_sequencer #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned SETTLE_CYCLES   = 2,
  parameter logic [4:0]  START_X         = 5'd1,
  parameter logic [4:0]  START_Y         = 5'd1
`ifdef MOVE_AUTOREPEAT_EN
  ,
  parameter int unsigned REPEAT_CYCLES   = 32
`endif
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [3:0] dir_n,
  input  logic [4:0] new_x_pos,
  input  logic [4:0] new_y_pos,
  output logic [2:0] move,
  output logic [4:0] current_x_pos,
  output logic [4:0] current_y_pos,
  output logic       moved,
  output logic       busy
);

  localparam int unsigned N_BTN = 4;
  localparam int unsigned DEB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned SET_W = $clog2(SETTLE_CYCLES + 1);
`ifdef MOVE_AUTOREPEAT_EN
  localparam int unsigned REP_W = $clog2(REPEAT_CYCLES + 1);
`endif

  localparam logic [2:0] MV_NONE  = 3'b000;
  localparam logic [2:0] MV_UP    = 3'b001;
  localparam logic [2:0] MV_DOWN  = 3'b010;
  localparam logic [2:0] MV_LEFT  = 3'b011;
  localparam logic [2:0] MV_RIGHT = 3'b100;

  typedef enum logic [1:0] {IDLE, ISSUE, COMMIT, HOLD} state_t;

  logic [N_BTN-1:0]            sync1, sync2, pressed;
  logic [N_BTN-1:0][DEB_W-1:0] deb_cnt;

  state_t           state, state_nxt;
  logic [2:0]       move_code, move_code_nxt, code_sel;
  logic [SET_W-1:0] settle_cnt, settle_nxt;
  logic [2:0]       move_nxt;
  logic [4:0]       x_nxt, y_nxt;
  logic             moved_nxt, busy_nxt;
`ifdef MOVE_AUTOREPEAT_EN
  logic [REP_W-1:0] rep_cnt, rep_nxt;
  logic [N_BTN-1:0] pressed_q;
  logic             release_any;
`endif

  // Two-flop synchroniser and per-button debounce; a level that disagrees
  // with the debounced state must persist DEBOUNCE_CYCLES cycles to flip it.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sync1   <= '1;
      sync2   <= '1;
      pressed <= '0;
      deb_cnt <= '0;
    end else begin
      sync1 <= dir_n;
      sync2 <= sync1;
      for (int i = 0; i < N_BTN; i++) begin
        if ((~sync2[i]) == pressed[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
          pressed[i] <= ~pressed[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + DEB_W'(1);
        end
      end
    end
  end

  // Fixed priority: up > down > left > right.
  always_comb begin
    code_sel = MV_NONE;
    if (pressed[3])      code_sel = MV_UP;
    else if (pressed[2]) code_sel = MV_DOWN;
    else if (pressed[1]) code_sel = MV_LEFT;
    else if (pressed[0]) code_sel = MV_RIGHT;
  end

`ifdef MOVE_AUTOREPEAT_EN
  assign release_any = |(pressed_q & ~pressed);
`endif

  // Next-state, commit and registered-output decode.
  always_comb begin
    state_nxt     = state;
    move_code_nxt = move_code;
    settle_nxt    = settle_cnt;
    x_nxt         = current_x_pos;
    y_nxt         = current_y_pos;
    moved_nxt     = 1'b0;
`ifdef MOVE_AUTOREPEAT_EN
    rep_nxt       = rep_cnt;
`endif
    case (state)
      IDLE: begin
        if (|pressed) begin
          state_nxt     = ISSUE;
          move_code_nxt = code_sel;
          settle_nxt    = '0;
        end
      end
      ISSUE: begin
        if (settle_cnt == SET_W'(SETTLE_CYCLES - 1)) begin
          state_nxt = COMMIT;
        end else begin
          settle_nxt = settle_cnt + SET_W'(1);
        end
      end
      COMMIT: begin
        x_nxt     = new_x_pos;
        y_nxt     = new_y_pos;
        moved_nxt = (new_x_pos != current_x_pos) || (new_y_pos != current_y_pos);
        state_nxt = HOLD;
`ifdef MOVE_AUTOREPEAT_EN
        rep_nxt   = '0;
`endif
      end
      HOLD: begin
`ifdef MOVE_AUTOREPEAT_EN
        if (!(|pressed)) begin
          state_nxt = IDLE;
          rep_nxt   = '0;
        end else if (release_any) begin
          rep_nxt = '0;
        end else if (rep_cnt == REP_W'(REPEAT_CYCLES - 1)) begin
          rep_nxt       = '0;
          state_nxt     = ISSUE;
          move_code_nxt = code_sel;
          settle_nxt    = '0;
        end else begin
          rep_nxt = rep_cnt + REP_W'(1);
        end
`else
        if (!(|pressed)) begin
          state_nxt = IDLE;
        end
`endif
      end
      default: state_nxt = IDLE;
    endcase
    move_nxt = ((state_nxt == ISSUE) || (state_nxt == COMMIT)) ? move_code_nxt : MV_NONE;
    busy_nxt = (state_nxt != IDLE);
  end

  // State, position and output registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state         <= IDLE;
      move_code     <= MV_NONE;
      settle_cnt    <= '0;
      move          <= MV_NONE;
      moved         <= 1'b0;
      busy          <= 1'b0;
      current_x_pos <= START_X;
      current_y_pos <= START_Y;
`ifdef MOVE_AUTOREPEAT_EN
      rep_cnt       <= '0;
      pressed_q     <= '0;
`endif
    end else begin
      state         <= state_nxt;
      move_code     <= move_code_nxt;
      settle_cnt    <= settle_nxt;
      move          <= move_nxt;
      moved         <= moved_nxt;
      busy          <= busy_nxt;
      current_x_pos <= x_nxt;
      current_y_pos <= y_nxt;
`ifdef MOVE_AUTOREPEAT_EN
      rep_cnt       <= rep_nxt;
      pressed_q     <= pressed;
`endif
    end
  end

endmodule

// File: tb/tb_move_sequencer.sv
// Directed bench for move_sequencer with a small collision-detector model.
module tb_move_sequencer;

  logic       clock;
  logic       resetn;
  logic [3:0] dir_n;
  logic [4:0] new_x_pos, new_y_pos;
  logic [2:0] move;
  logic [4:0] current_x_pos, current_y_pos;
  logic       moved, busy;

  // 0: normal clamped detector, 1: every move blocked, 2: forced result
  int         mode;
  logic [4:0] force_x, force_y;

  int n_checks = 0;
  int n_errors = 0;

  move_sequencer dut (
    .clock         (clock),
    .resetn        (resetn),
    .dir_n         (dir_n),
    .new_x_pos     (new_x_pos),
    .new_y_pos     (new_y_pos),
    .move          (move),
    .current_x_pos (current_x_pos),
    .current_y_pos (current_y_pos),
    .moved         (moved),
    .busy          (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Detector model: one step in the move direction, clamped to 0..31.
  always_comb begin
    new_x_pos = current_x_pos;
    new_y_pos = current_y_pos;
    if (mode == 2) begin
      new_x_pos = force_x;
      new_y_pos = force_y;
    end else if (mode == 0) begin
      case (move)
        3'b001: if (current_y_pos != 5'd0)  new_y_pos = current_y_pos - 5'd1;
        3'b010: if (current_y_pos != 5'd31) new_y_pos = current_y_pos + 5'd1;
        3'b011: if (current_x_pos != 5'd0)  new_x_pos = current_x_pos - 5'd1;
        3'b100: if (current_x_pos != 5'd31) new_x_pos = current_x_pos + 5'd1;
        default: ;
      endcase
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_busy(input string tag);
    int k;
    k = 0;
    while (!busy && k < 60) begin
      @(negedge clock);
      k++;
    end
    check_val(tag, 32'(busy), 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while (busy && k < 80) begin
      @(negedge clock);
      k++;
    end
    check_val(tag, 32'(busy), 32'd0);
  endtask

  int mv_cnt, moved_cnt, exp_rep;
  logic saw_busy;

  initial begin
    resetn  = 1'b0;
    dir_n   = 4'hF;
    mode    = 0;
    force_x = 5'd0;
    force_y = 5'd0;
    repeat (3) @(negedge clock);
    check_val("rst_move", 32'(move), 32'd0);
    check_val("rst_x", 32'(current_x_pos), 32'd1);
    check_val("rst_y", 32'(current_y_pos), 32'd1);
    check_val("rst_moved", 32'(moved), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    resetn = 1'b1;
    repeat (3) @(negedge clock);
    check_val("post_rst_busy", 32'(busy), 32'd0);

    // Up from (1,1): ISSUE starts 19 cycles after the press is driven.
    dir_n = 4'b0111;
    mv_cnt = 0; moved_cnt = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clock);
      if (k == 18) check_val("up_idle_k18", 32'(busy), 32'd0);
      if (k == 19) check_val("up_busy_k19", 32'(busy), 32'd1);
      if (move == 3'b001) mv_cnt++;
      if (moved) moved_cnt++;
    end
    check_val("up_move_cycles", 32'(mv_cnt), 32'd3);
    check_val("up_moved_pulses", 32'(moved_cnt), 32'd1);
    check_val("up_x", 32'(current_x_pos), 32'd1);
    check_val("up_y", 32'(current_y_pos), 32'd0);
    check_val("up_hold_busy", 32'(busy), 32'd1);
    check_val("up_hold_move", 32'(move), 32'd0);
    dir_n = 4'hF;
    wait_idle("up_release");

    // Blocked right: detector returns the current position.
    mode = 1;
    dir_n = 4'b1110;
    moved_cnt = 0; saw_busy = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clock);
      if (busy) saw_busy = 1'b1;
      if (moved) moved_cnt++;
    end
    check_val("blk_saw_busy", 32'(saw_busy), 32'd1);
    check_val("blk_moved", 32'(moved_cnt), 32'd0);
    check_val("blk_x", 32'(current_x_pos), 32'd1);
    check_val("blk_y", 32'(current_y_pos), 32'd0);
    check_val("blk_in_hold", 32'(busy), 32'd1);
    dir_n = 4'hF;
    wait_idle("blk_release");
    mode = 0;

    // Glitchy down press: 10 low, 1 high, then a full stable window.
    dir_n = 4'b1011;
    saw_busy = 1'b0;
    repeat (10) begin
      @(negedge clock);
      if (busy) saw_busy = 1'b1;
    end
    dir_n = 4'hF;
    @(negedge clock);
    if (busy) saw_busy = 1'b1;
    dir_n = 4'b1011;
    moved_cnt = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clock);
      if (k < 18 && busy) saw_busy = 1'b1;
      if (k == 18) check_val("glitch_idle_k18", 32'(busy), 32'd0);
      if (k == 19) check_val("glitch_busy_k19", 32'(busy), 32'd1);
      if (moved) moved_cnt++;
    end
    check_val("glitch_no_early", 32'(saw_busy), 32'd0);
    check_val("glitch_moved", 32'(moved_cnt), 32'd1);
    check_val("glitch_y", 32'(current_y_pos), 32'd1);
    dir_n = 4'hF;
    wait_idle("glitch_release");

    // Up+down together: up wins and stays latched despite a new button.
    dir_n = 4'b0011;
    wait_busy("simul_start");
    check_val("simul_prio", 32'(move), 32'd1);
    dir_n = 4'b1110;
    @(negedge clock);
    check_val("simul_latched_1", 32'(move), 32'd1);
    @(negedge clock);
    check_val("simul_latched_2", 32'(move), 32'd1);
    moved_cnt = 0;
    repeat (8) begin
      @(negedge clock);
      if (moved) moved_cnt++;
    end
    check_val("simul_moved", 32'(moved_cnt), 32'd1);
    check_val("simul_x", 32'(current_x_pos), 32'd1);
    check_val("simul_y", 32'(current_y_pos), 32'd0);
    dir_n = 4'hF;
    wait_idle("simul_release");

    // Hold right for 200 cycles; with auto-repeat a commit every 35 cycles.
`ifdef MOVE_AUTOREPEAT_EN
    exp_rep = 1 + (200 - 22) / (32 + 2 + 1);
`else
    exp_rep = 1;
`endif
    dir_n = 4'b1110;
    moved_cnt = 0;
    repeat (200) begin
      @(negedge clock);
      if (moved) moved_cnt++;
    end
    check_val("hold_commits", 32'(moved_cnt), 32'(exp_rep));
    check_val("hold_x", 32'(current_x_pos), 32'(1 + exp_rep));
    dir_n = 4'hF;
    wait_idle("hold_release");

    // Detector result is committed verbatim, whatever it is.
    mode = 2;
    force_x = 5'd31;
    force_y = 5'd17;
    dir_n = 4'b1101;
    moved_cnt = 0;
    repeat (30) begin
      @(negedge clock);
      if (moved) moved_cnt++;
    end
    check_val("force_moved", 32'(moved_cnt), 32'd1);
    check_val("force_x", 32'(current_x_pos), 32'd31);
    check_val("force_y", 32'(current_y_pos), 32'd17);
    dir_n = 4'hF;
    wait_idle("force_release");
    mode = 0;

    // Asynchronous reset in the middle of ISSUE.
    dir_n = 4'b1011;
    wait_busy("mid_rst_start");
    #2 resetn = 1'b0;
    #1;
    check_val("mid_rst_move", 32'(move), 32'd0);
    check_val("mid_rst_x", 32'(current_x_pos), 32'd1);
    check_val("mid_rst_y", 32'(current_y_pos), 32'd1);
    check_val("mid_rst_moved", 32'(moved), 32'd0);
    check_val("mid_rst_busy", 32'(busy), 32'd0);
    dir_n = 4'hF;
    repeat (3) @(negedge clock);
    resetn = 1'b1;
    moved_cnt = 0;
    repeat (10) begin
      @(negedge clock);
      if (moved) moved_cnt++;
    end
    check_val("mid_rst_no_pulse", 32'(moved_cnt), 32'd0);
    check_val("mid_rst_idle", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
